// File: rtl/nx_axi4s_pack_bridge.sv
// nx_axi4s_pack_bridge: AXI4-stream <-> Nexus bridge carrying one
// 31-bit message per 32-bit slot; unpacks inbound beats, packs outbound.
module nx_axi4s_pack_bridge #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int MSG_WIDTH       = 31,
  parameter int FLUSH_CYCLES    = 16,
  parameter int IDLE_W          = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AXI4_DATA_WIDTH-1:0] ib_axi4s_tdata_i,
  input  logic                       ib_axi4s_tlast_i,
  input  logic                       ib_axi4s_tvalid_i,
  output logic                       ib_axi4s_tready_o,
  output logic [MSG_WIDTH-1:0]       ob_nx_data_o,
  output logic                       ob_nx_valid_o,
  input  logic                       ob_nx_ready_i,
  input  logic [MSG_WIDTH-1:0]       ib_nx_data_i,
  input  logic                       ib_nx_valid_i,
  output logic                       ib_nx_ready_o,
  output logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata_o,
  output logic                       ob_axi4s_tlast_o,
  output logic                       ob_axi4s_tvalid_o,
  input  logic                       ob_axi4s_tready_i,
  input  logic                       flush_i,
  output logic                       idle_o
);

  localparam int SLOTS = AXI4_DATA_WIDTH / 32;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);
  localparam logic [IDLE_W-1:0] FLUSH_V = IDLE_W'(FLUSH_CYCLES);
  localparam bit TO_EN = (FLUSH_CYCLES > 0);

  logic unused_tlast;
  assign unused_tlast = ib_axi4s_tlast_i;

  logic [MSG_WIDTH-1:0] umsg_q [SLOTS];
  logic [MSG_WIDTH-1:0] umsg_d [SLOTS];
  logic [SLOTS-1:0]     mask_q, mask_d;
  logic [SLOTS-1:0]     slot_vld, head;
  logic [MSG_WIDTH-1:0] head_msg;
  logic                 ib_acc, nx_out_acc;

  // head isolates the lowest pending slot
  always_comb begin
    head     = mask_q & (~mask_q + SLOTS'(1));
    head_msg = '0;
    slot_vld = '0;
    for (int k = 0; k < SLOTS; k++) begin
      slot_vld[k] = ib_axi4s_tdata_i[32*k+31];
      if (head[k]) head_msg = head_msg | umsg_q[k];
    end
  end

  assign ib_axi4s_tready_o = (mask_q == '0);
  assign ob_nx_valid_o     = |mask_q;
  assign ob_nx_data_o      = head_msg;
  assign ib_acc            = ib_axi4s_tvalid_i & ib_axi4s_tready_o;
  assign nx_out_acc        = ob_nx_valid_o & ob_nx_ready_i;

  always_comb begin
    mask_d = mask_q;
    umsg_d = umsg_q;
    if (ib_acc) begin
      mask_d = slot_vld;
      for (int k = 0; k < SLOTS; k++)
        umsg_d[k] = ib_axi4s_tdata_i[32*k +: MSG_WIDTH];
    end else if (nx_out_acc) begin
      mask_d = mask_q & ~head;
    end
  end

  logic [AXI4_DATA_WIDTH-1:0] pbuf_q, pbuf_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_base;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic                       pend_q, pend_d;
  logic [AXI4_DATA_WIDTH-1:0] od_q, od_d;
  logic                       ol_q, ol_d;
  logic                       ov_q, ov_d;
  logic                       nx_acc, full, to_fire, can_load, xfer;

  assign ib_nx_ready_o = (cnt_q < FULL_CNT);
  assign nx_acc        = ib_nx_valid_i & ib_nx_ready_o;
  assign full          = (cnt_q == FULL_CNT);
  assign can_load      = ~ov_q | ob_axi4s_tready_i;

  // an accept in the firing cycle suppresses the timeout
  assign to_fire = TO_EN && (idle_q == FLUSH_V) && !nx_acc
                 && (cnt_q != '0) && !full;

  assign xfer = can_load
              & (full | ((pend_q | to_fire) & (cnt_q != '0)));

  always_comb begin
    pbuf_d   = xfer ? '0 : pbuf_q;
    cnt_base = xfer ? '0 : cnt_q;
    for (int k = 0; k < SLOTS; k++)
      if (nx_acc && cnt_base == CNT_W'(k))
        pbuf_d[32*k +: 32] = {1'b1, ib_nx_data_i};
    cnt_d = cnt_base + CNT_W'(nx_acc);
  end

  always_comb begin
    idle_d = idle_q;
    if (nx_acc || xfer || cnt_q == '0)
      idle_d = '0;
    else if (!full && idle_q != '1)
      idle_d = idle_q + IDLE_W'(1);
  end

  // a flush covers the message accepted alongside it
  assign pend_d = ((pend_q | to_fire) & ~xfer)
                | (flush_i & (cnt_d != '0));

  always_comb begin
    od_d = od_q;
    ol_d = ol_q;
    ov_d = ov_q;
    if (xfer) begin
      od_d = pbuf_q;
      ol_d = ~full;
      ov_d = 1'b1;
    end else if (ov_q && ob_axi4s_tready_i) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      for (int k = 0; k < SLOTS; k++) umsg_q[k] <= '0;
      pbuf_q <= '0;
      cnt_q  <= '0;
      idle_q <= '0;
      pend_q <= 1'b0;
      od_q   <= '0;
      ol_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      mask_q <= mask_d;
      umsg_q <= umsg_d;
      pbuf_q <= pbuf_d;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
      pend_q <= pend_d;
      od_q   <= od_d;
      ol_q   <= ol_d;
      ov_q   <= ov_d;
    end
  end

  assign ob_axi4s_tdata_o  = od_q;
  assign ob_axi4s_tlast_o  = ol_q;
  assign ob_axi4s_tvalid_o = ov_q;
  assign idle_o = (mask_q == '0) && (cnt_q == '0) && !ov_q;

endmodule

// File: tb/tb_nx_axi4s_pack_bridge.sv
// tb_nx_axi4s_pack_bridge: directed and random stimulus against a
// queue-based reference model of the unpack and pack paths.
module tb_nx_axi4s_pack_bridge;

  localparam int W = 128;
  localparam int S = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic [W-1:0]  ib_axi4s_tdata_i;
  logic          ib_axi4s_tlast_i;
  logic          ib_axi4s_tvalid_i;
  logic          ib_axi4s_tready_o;
  logic [30:0]   ob_nx_data_o;
  logic          ob_nx_valid_o;
  logic          ob_nx_ready_i;
  logic [30:0]   ib_nx_data_i;
  logic          ib_nx_valid_i;
  logic          ib_nx_ready_o;
  logic [W-1:0]  ob_axi4s_tdata_o;
  logic          ob_axi4s_tlast_o;
  logic          ob_axi4s_tvalid_o;
  logic          ob_axi4s_tready_i;
  logic          flush_i;
  logic          idle_o;

  nx_axi4s_pack_bridge #(
    .AXI4_DATA_WIDTH(W),
    .MSG_WIDTH(31),
    .FLUSH_CYCLES(F),
    .IDLE_W(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .ib_axi4s_tdata_i(ib_axi4s_tdata_i),
    .ib_axi4s_tlast_i(ib_axi4s_tlast_i),
    .ib_axi4s_tvalid_i(ib_axi4s_tvalid_i),
    .ib_axi4s_tready_o(ib_axi4s_tready_o),
    .ob_nx_data_o(ob_nx_data_o),
    .ob_nx_valid_o(ob_nx_valid_o),
    .ob_nx_ready_i(ob_nx_ready_i),
    .ib_nx_data_i(ib_nx_data_i),
    .ib_nx_valid_i(ib_nx_valid_i),
    .ib_nx_ready_o(ib_nx_ready_o),
    .ob_axi4s_tdata_o(ob_axi4s_tdata_o),
    .ob_axi4s_tlast_o(ob_axi4s_tlast_o),
    .ob_axi4s_tvalid_o(ob_axi4s_tvalid_o),
    .ob_axi4s_tready_i(ob_axi4s_tready_i),
    .flush_i(flush_i),
    .idle_o(idle_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model state
  logic [30:0]  uq[$];
  logic [30:0]  cur[$];
  logic [W:0]   bq[$];
  int           t = 0;
  int           last_acc = -1000;
  bit           nacc_last = 0;

  task automatic emit(input bit last);
    logic [W:0] b;
    b = '0;
    b[W] = last;
    foreach (cur[i]) b[32*i +: 32] = {1'b1, cur[i]};
    bq.push_back(b);
    cur.delete();
  endtask

  task automatic mon();
    bit nacc;
    chk("ib_tready", ib_axi4s_tready_o, uq.size() == 0);
    chk("nx_valid", ob_nx_valid_o, uq.size() != 0);
    if (ob_nx_valid_o && uq.size() != 0) begin
      chk("nx_data", ob_nx_data_o, uq[0]);
      if (ob_nx_ready_i) void'(uq.pop_front());
    end
    if (ib_axi4s_tvalid_i && ib_axi4s_tready_o)
      for (int k = 0; k < S; k++)
        if (ib_axi4s_tdata_i[32*k+31])
          uq.push_back(ib_axi4s_tdata_i[32*k +: 31]);

    if (ob_axi4s_tvalid_o) begin
      chk("ob_expected", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        chk("ob_data", ob_axi4s_tdata_o, bq[0][W-1:0]);
        chk("ob_last", ob_axi4s_tlast_o, bq[0][W]);
        if (ob_axi4s_tready_i) void'(bq.pop_front());
      end
    end

    nacc = ib_nx_valid_i & ib_nx_ready_o;
    nacc_last = nacc;
    if (nacc) begin
      cur.push_back(ib_nx_data_i);
      last_acc = t;
      if (cur.size() == S) emit(1'b0);
    end
    if (flush_i && cur.size() != 0) emit(1'b1);
    else if (cur.size() != 0 && !nacc && t - last_acc == F + 1)
      emit(1'b1);
    t++;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    uq.delete();
    cur.delete();
    bq.delete();
  endtask

  task automatic send(input logic [30:0] m, output int waits);
    ib_nx_data_i  = m;
    ib_nx_valid_i = 1'b1;
    waits = 0;
    while (!ib_nx_ready_o && waits < 50) begin
      cyc();
      waits++;
    end
    chk("send_rdy", ib_nx_ready_o, 1);
    cyc();
    ib_nx_valid_i = 1'b0;
  endtask

  task automatic wait_ob(output int n);
    n = 0;
    while (!ob_axi4s_tvalid_o && n < 40) begin
      cyc();
      n++;
    end
    chk("ob_wait", ob_axi4s_tvalid_o, 1);
  endtask

  int w, n, gap;

  initial begin
    rst_i = 1'b1;
    ib_axi4s_tdata_i = '0;
    ib_axi4s_tlast_i = 1'b0;
    ib_axi4s_tvalid_i = 1'b0;
    ob_nx_ready_i = 1'b1;
    ib_nx_data_i = '0;
    ib_nx_valid_i = 1'b0;
    ob_axi4s_tready_i = 1'b1;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", ib_axi4s_tready_o, 1);
    chk("rst_nx_valid", ob_nx_valid_o, 0);
    chk("rst_nx_ready", ib_nx_ready_o, 1);
    chk("rst_tvalid", ob_axi4s_tvalid_o, 0);
    chk("rst_tdata", ob_axi4s_tdata_o, 0);
    chk("rst_tlast", ob_axi4s_tlast_o, 0);
    chk("rst_idle", idle_o, 1);
    rst_i = 1'b0;

    // unpack three messages, lowest slot first
    ib_axi4s_tdata_i = 128'h80000001_00000000_8000000A_80000005;
    ib_axi4s_tvalid_i = 1'b1;
    cyc();
    ib_axi4s_tvalid_i = 1'b0;
    chk("unpack_first_v", ob_nx_valid_o, 1);
    chk("unpack_first_d", ob_nx_data_o, 31'h5);
    n = 1;
    while (!ib_axi4s_tready_o && n < 10) begin
      cyc();
      n++;
    end
    chk("unpack_tready_lat", n, 4);

    // all-invalid beat is dropped
    ib_axi4s_tdata_i = '0;
    ib_axi4s_tvalid_i = 1'b1;
    cyc();
    chk("drop_tready", ib_axi4s_tready_o, 1);
    chk("drop_nx_valid", ob_nx_valid_o, 0);
    ib_axi4s_tdata_i = 128'h80000033;
    cyc();
    ib_axi4s_tvalid_i = 1'b0;
    chk("drop_next_v", ob_nx_valid_o, 1);
    chk("drop_next_d", ob_nx_data_o, 31'h33);
    repeat (3) cyc();

    // full pack
    for (int i = 1; i <= 4; i++) begin
      send(31'(i), w);
      chk("full_no_wait", w, 0);
    end
    wait_ob(n);
    chk("full_data", ob_axi4s_tdata_o,
        128'h80000004_80000003_80000002_80000001);
    chk("full_last", ob_axi4s_tlast_o, 0);
    cyc();

    // timeout of a partial beat
    send(31'h7F, w);
    wait_ob(n);
    chk("to_lat", n, F + 1);
    chk("to_data", ob_axi4s_tdata_o, 128'h8000007F);
    chk("to_last", ob_axi4s_tlast_o, 1);
    cyc();

    // flush with nothing buffered
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    repeat (20) cyc();
    chk("flush_empty_tv", ob_axi4s_tvalid_o, 0);
    chk("flush_empty_idle", idle_o, 1);

    // flush together with an accept
    ib_nx_data_i = 31'h55;
    ib_nx_valid_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    ib_nx_valid_i = 1'b0;
    flush_i = 1'b0;
    wait_ob(n);
    chk("flush_acc_data", ob_axi4s_tdata_o, 128'h80000055);
    chk("flush_acc_last", ob_axi4s_tlast_o, 1);
    cyc();

    // backpressure with two full beats
    ob_axi4s_tready_i = 1'b0;
    for (int i = 1; i <= 8; i++) send(31'(i), w);
    chk("bp_nx_ready", ib_nx_ready_o, 0);
    repeat (5) cyc();
    chk("bp_hold_v", ob_axi4s_tvalid_o, 1);
    chk("bp_hold_d", ob_axi4s_tdata_o,
        128'h80000004_80000003_80000002_80000001);
    ob_axi4s_tready_i = 1'b1;
    repeat (10) cyc();
    chk("bp_drained", bq.size(), 0);
    chk("bp_idle", idle_o, 1);

    // reset with two messages pending
    ob_nx_ready_i = 1'b0;
    ib_axi4s_tdata_i = 128'h00000000_80000003_80000002_80000001;
    ib_axi4s_tvalid_i = 1'b1;
    cyc();
    ib_axi4s_tvalid_i = 1'b0;
    ob_nx_ready_i = 1'b1;
    cyc();
    ob_nx_ready_i = 1'b0;
    chk("rst_mid_pend", ob_nx_valid_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    clear_model();
    chk("rst_mid_nx_valid", ob_nx_valid_o, 0);
    chk("rst_mid_tready", ib_axi4s_tready_o, 1);
    chk("rst_mid_idle", idle_o, 1);

    // random unpack traffic
    for (int c = 0; c < 400; c++) begin
      if (!ib_axi4s_tvalid_i || ib_axi4s_tready_o) begin
        ib_axi4s_tvalid_i = ($urandom % 2) == 0;
        for (int k = 0; k < S; k++)
          ib_axi4s_tdata_i[32*k +: 32] =
            {1'($urandom_range(0, 1)), 31'($urandom)};
      end
      ob_nx_ready_i = ($urandom % 4) != 0;
      cyc();
    end
    ib_axi4s_tvalid_i = 1'b0;
    ob_nx_ready_i = 1'b1;
    repeat (20) cyc();
    chk("rnd_unpack_drain", uq.size(), 0);

    // random pack traffic with gaps and flushes
    gap = 0;
    for (int c = 0; c < 800; c++) begin
      if (!ib_nx_valid_i || nacc_last) begin
        if (gap > 0) begin
          gap--;
          ib_nx_valid_i = 1'b0;
        end else if ($urandom % 20 == 0) begin
          gap = $urandom_range(5, 14);
          ib_nx_valid_i = 1'b0;
        end else begin
          ib_nx_valid_i = ($urandom % 3) != 0;
          ib_nx_data_i = 31'($urandom);
        end
      end
      flush_i = ($urandom % 24) == 0;
      cyc();
    end
    ib_nx_valid_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    repeat (20) cyc();
    chk("rnd_pack_drain", bq.size(), 0);
    chk("rnd_pack_cur", cur.size(), 0);
    chk("rnd_pack_idle", idle_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
